// File: rtl/sigdel_seq_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : sigdel_seq_ctrl                                              |
// | Description : Sigma-delta decimation sequencer. Generates fsclk/fbwclk     |
// |               enables, discards settling words, and holds each decimated   |
// |               word for a valid/ready consumer with sticky overrun.         |
// | Options     : SIGDEL_OVR_CNT_EN adds the saturating ovr_cnt output.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module sigdel_seq_ctrl #(
  parameter int DIV_W  = 8,
  parameter int OSR_W  = 8,
  parameter int DW     = 16,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] fs_div,
  input  logic [OSR_W-1:0] osr,
  input  logic             ovr_clr,
  input  logic [DW-1:0]    filt_in,
  output logic             fsclk,
  output logic             fbwclk,
  output logic [DW-1:0]    dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  output logic             busy
`ifdef SIGDEL_OVR_CNT_EN
  ,
  output logic [7:0]       ovr_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  localparam logic [4:0] c_SETTLE = 5'(SETTLE);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_fs_div_l;
  logic [OSR_W-1:0] r_osr_l;
  logic [DIV_W-1:0] r_fs_cnt;
  logic [OSR_W-1:0] r_dec_cnt;
  logic [3:0]       r_settle_cnt;
  logic             r_cap_pend;
  logic             r_fsclk;
  logic             r_fbwclk;
  logic [DW-1:0]    r_dout;
  logic             r_dout_valid;
  logic             r_overrun;

  logic w_start;
  logic w_active;
  logic w_fs_hit;
  logic w_dec_hit;
  logic w_cap;
  logic w_settle_done;
  logic w_load;
  logic w_consume;
  logic w_ovr_evt;

  // A pending request is dropped as soon as en is seen low, so the counters
  // only advance while the state is active and en is still asserted.
  assign w_start       = (r_state == S_IDLE) && en;
  assign w_active      = (r_state != S_IDLE) && en;
  assign w_fs_hit      = w_active && (r_fs_cnt == r_fs_div_l);
  assign w_dec_hit     = w_fs_hit && (r_dec_cnt == r_osr_l);
  assign w_cap         = w_active && r_cap_pend;
  assign w_settle_done = w_cap && (r_state == S_SETTLE) &&
                         (({1'b0, r_settle_cnt} + 5'd1) == c_SETTLE);
  assign w_load        = w_cap && (r_state == S_RUN);
  assign w_consume     = r_dout_valid && dout_ready;
  assign w_ovr_evt     = w_load && r_dout_valid && !dout_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_state_nxt = (c_SETTLE == 5'd0) ? S_RUN : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (!en) begin
          w_state_nxt = S_IDLE;
        end else if (w_settle_done) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!en) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fs_div_l <= '0;
      r_osr_l    <= '0;
    end else if (w_start) begin
      r_fs_div_l <= fs_div;
      r_osr_l    <= osr;
    end
  end

  // Rate generation: fsclk/fbwclk are registered, so they land one cycle
  // after the prescaler match that produces them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fs_cnt     <= '0;
      r_dec_cnt    <= '0;
      r_settle_cnt <= '0;
      r_cap_pend   <= 1'b0;
      r_fsclk      <= 1'b0;
      r_fbwclk     <= 1'b0;
    end else if (!w_active) begin
      r_fs_cnt     <= '0;
      r_dec_cnt    <= '0;
      r_settle_cnt <= '0;
      r_cap_pend   <= 1'b0;
      r_fsclk      <= 1'b0;
      r_fbwclk     <= 1'b0;
    end else begin
      r_fs_cnt   <= w_fs_hit ? '0 : r_fs_cnt + 1'b1;
      r_fsclk    <= w_fs_hit;
      r_fbwclk   <= w_dec_hit;
      r_cap_pend <= r_fbwclk;
      if (w_fs_hit) begin
        r_dec_cnt <= w_dec_hit ? '0 : r_dec_cnt + 1'b1;
      end
      if (w_cap && (r_state == S_SETTLE)) begin
        r_settle_cnt <= r_settle_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else if (w_load) begin
      r_dout       <= filt_in;
      r_dout_valid <= 1'b1;
    end else if (w_consume) begin
      r_dout_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_ovr_evt) begin
      r_overrun <= 1'b1;
    end else if (ovr_clr) begin
      r_overrun <= 1'b0;
    end
  end

`ifdef SIGDEL_OVR_CNT_EN
  logic [7:0] r_ovr_cnt;

  // A clear coinciding with a new event counts that event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovr_cnt <= 8'd0;
    end else if (ovr_clr) begin
      r_ovr_cnt <= w_ovr_evt ? 8'd1 : 8'd0;
    end else if (w_ovr_evt && (r_ovr_cnt != 8'hFF)) begin
      r_ovr_cnt <= r_ovr_cnt + 8'd1;
    end
  end

  assign ovr_cnt = r_ovr_cnt;
`endif

  assign fsclk      = r_fsclk;
  assign fbwclk     = r_fbwclk;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign overrun    = r_overrun;
  assign busy       = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sigdel_seq_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_sigdel_seq_ctrl                                           |
// | Description : Directed self-checking bench for sigdel_seq_ctrl.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sigdel_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  fs_div;
  logic [7:0]  osr;
  logic        ovr_clr;
  logic [15:0] filt_in;
  logic        fsclk;
  logic        fbwclk;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        overrun;
  logic        busy;
`ifdef SIGDEL_OVR_CNT_EN
  logic [7:0]  ovr_cnt;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [15:0] hist [0:511];
  logic [15:0] old_word;

  sigdel_seq_ctrl #(
    .DIV_W (8),
    .OSR_W (8),
    .DW    (16),
    .SETTLE(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .fs_div    (fs_div),
    .osr       (osr),
    .ovr_clr   (ovr_clr),
    .filt_in   (filt_in),
    .fsclk     (fsclk),
    .fbwclk    (fbwclk),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .overrun   (overrun),
    .busy      (busy)
`ifdef SIGDEL_OVR_CNT_EN
    ,
    .ovr_cnt   (ovr_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // filt_in follows a free-running cycle count, updated just after each edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    filt_in = cyc[15:0];
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    en         = 1'b0;
    ovr_clr    = 1'b0;
    dout_ready = 1'b0;
    fs_div     = 8'd3;
    osr        = 8'd7;
    filt_in    = 16'd0;
    step();
    step();
    check("rst_fsclk",   32'(fsclk),      32'd0);
    check("rst_fbwclk",  32'(fbwclk),     32'd0);
    check("rst_dout",    32'(dout),       32'd0);
    check("rst_valid",   32'(dout_valid), 32'd0);
    check("rst_overrun", 32'(overrun),    32'd0);
    check("rst_busy",    32'(busy),       32'd0);
    rst_n = 1'b1;
    step();
    check("idle_busy", 32'(busy), 32'd0);

    // Reset in the middle of a run, on a cycle where both enables are high.
    en = 1'b1;
    step();
    for (int c = 0; c <= 128; c++) begin
      hist[c] = filt_in;
      check($sformatf("a_fsclk@%0d", c),  32'(fsclk),      32'(c >= 4 && c % 4 == 0));
      check($sformatf("a_fbwclk@%0d", c), 32'(fbwclk),     32'(c >= 32 && c % 32 == 0));
      check($sformatf("a_valid@%0d", c),  32'(dout_valid), 32'(c >= 98));
      if (c == 98)  check("a_dout98", 32'(dout), 32'(hist[97]));
      if (c == 128) check("a_dout128", 32'(dout), 32'(hist[97]));
      if (c < 128) step();
    end
    rst_n = 1'b0;
    #2;
    check("mid_rst_fsclk",   32'(fsclk),      32'd0);
    check("mid_rst_fbwclk",  32'(fbwclk),     32'd0);
    check("mid_rst_dout",    32'(dout),       32'd0);
    check("mid_rst_valid",   32'(dout_valid), 32'd0);
    check("mid_rst_overrun", 32'(overrun),    32'd0);
    check("mid_rst_busy",    32'(busy),       32'd0);
    en = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("post_rst_fsclk%0d", i), 32'(fsclk), 32'd0);
      check($sformatf("post_rst_busy%0d", i),  32'(busy),  32'd0);
    end

    // fs_div=3, osr=3: settle discard, capture latency, overrun, clear.
    fs_div = 8'd3;
    osr    = 8'd3;
    en     = 1'b1;
    step();
    for (int c = 0; c <= 90; c++) begin
      hist[c] = filt_in;
      check($sformatf("b_fsclk@%0d", c),  32'(fsclk),      32'(c >= 4 && c % 4 == 0));
      check($sformatf("b_fbwclk@%0d", c), 32'(fbwclk),     32'(c >= 16 && c % 16 == 0));
      check($sformatf("b_busy@%0d", c),   32'(busy),       32'd1);
      check($sformatf("b_valid@%0d", c),  32'(dout_valid), 32'(c >= 50));
      check($sformatf("b_ovr@%0d", c),    32'(overrun),    32'(c == 66 || c >= 82));
      if (c == 50) check("b_dout50", 32'(dout), 32'(hist[49]));
      if (c == 66) check("b_dout66", 32'(dout), 32'(hist[65]));
      if (c == 82) check("b_dout82", 32'(dout), 32'(hist[81]));
      if (c == 20) fs_div = 8'd7;
      ovr_clr = (c == 66 || c == 81);
      if (c == 90) en = 1'b0;
      step();
    end
    old_word = hist[81];
    check("stop_fsclk",   32'(fsclk),      32'd0);
    check("stop_fbwclk",  32'(fbwclk),     32'd0);
    check("stop_busy",    32'(busy),       32'd0);
    check("stop_valid",   32'(dout_valid), 32'd1);
    check("stop_dout",    32'(dout),       32'(old_word));
    check("stop_overrun", 32'(overrun),    32'd1);
    ovr_clr    = 1'b1;
    dout_ready = 1'b1;
    step();
    check("idle_clr_overrun", 32'(overrun),    32'd0);
    check("idle_consume",     32'(dout_valid), 32'd0);
    check("idle_dout_keep",   32'(dout),       32'(old_word));
    ovr_clr    = 1'b0;
    dout_ready = 1'b0;

    // Restart picks up fs_div=7; settle discard repeats.
    en = 1'b1;
    step();
    for (int c = 0; c <= 100; c++) begin
      hist[c] = filt_in;
      check($sformatf("c_fsclk@%0d", c),  32'(fsclk),      32'(c >= 8 && c % 8 == 0));
      check($sformatf("c_fbwclk@%0d", c), 32'(fbwclk),     32'(c >= 32 && c % 32 == 0));
      check($sformatf("c_valid@%0d", c),  32'(dout_valid), 32'(c >= 98));
      check($sformatf("c_ovr@%0d", c),    32'(overrun),    32'd0);
      if (c < 98)  check($sformatf("c_keep@%0d", c), 32'(dout), 32'(old_word));
      if (c == 98) check("c_dout98", 32'(dout), 32'(hist[97]));
      if (c == 100) en = 1'b0;
      step();
    end

    // fs_div=0, osr=0 with dout_ready held: word every cycle, no overrun.
    fs_div     = 8'd0;
    osr        = 8'd0;
    dout_ready = 1'b1;
    en         = 1'b1;
    step();
    for (int c = 0; c <= 20; c++) begin
      hist[c] = filt_in;
      check($sformatf("d_fsclk@%0d", c),  32'(fsclk),      32'(c >= 1));
      check($sformatf("d_fbwclk@%0d", c), 32'(fbwclk),     32'(c >= 1));
      check($sformatf("d_valid@%0d", c),  32'(dout_valid), 32'(c >= 5));
      check($sformatf("d_ovr@%0d", c),    32'(overrun),    32'd0);
      if (c >= 5) check($sformatf("d_dout@%0d", c), 32'(dout), 32'(hist[c-1]));
      if (c == 20) en = 1'b0;
      step();
    end

`ifdef SIGDEL_OVR_CNT_EN
    dout_ready = 1'b0;
    en         = 1'b1;
    step();
    for (int c = 0; c <= 322; c++) begin
      if (c == 100) check("e_cnt100", 32'(ovr_cnt), 32'd95);
      if (c == 320) check("e_cnt_sat", 32'(ovr_cnt), 32'd255);
      if (c == 321) check("e_cnt_clr_evt", 32'(ovr_cnt), 32'd1);
      if (c == 322) check("e_cnt_clr", 32'(ovr_cnt), 32'd0);
      ovr_clr = (c == 320 || c == 321);
      if (c == 321) en = 1'b0;
      step();
    end
    ovr_clr = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
